// File: rtl/alu_ctl_mc.sv
// Registered ALU-control decoder for the Exe stage: decodes ALUOp/Funct into an ALU select,
// and holds the select while a multi-cycle mul/div occupies the ALU.
module alu_ctl_mc #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [15:0]      immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] alu_sel,
  output logic             shamt_imm,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  // Counter preload: BUSY lasts LAT-1 cycles, so the counter starts at LAT-2.
  localparam logic [CntW-1:0] MulCnt = CntW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CntW-1:0] DivCnt = CntW'((DIV_LAT > 1) ? (DIV_LAT - 2) : 0);
  localparam bit MulMc = (MUL_LAT > 1);
  localparam bit DivMc = (DIV_LAT > 1);

  typedef enum logic [1:0] {StIdle, StBusy, StOut} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              shamt_q, shamt_d;
  logic              illegal_q, illegal_d;

  logic [FUNCT_W-1:0] funct;
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_shamt;
  logic               dec_illegal;
  logic               dec_mul;
  logic               dec_div;
  logic               accept;
  logic               unused_imm;

  assign funct      = immediate[FUNCT_W-1:0];
  assign unused_imm = ^immediate[15:FUNCT_W];

  always_comb begin
    dec_sel     = '0;
    dec_shamt   = 1'b0;
    dec_illegal = 1'b0;
    if (alu_op == OP_W'(0)) begin
      case (funct)
        FUNCT_W'(6'h00): begin dec_sel = SEL_W'(5'h00); dec_shamt = 1'b1; end
        FUNCT_W'(6'h02): begin dec_sel = SEL_W'(5'h01); dec_shamt = 1'b1; end
        FUNCT_W'(6'h04): dec_sel = SEL_W'(5'h00);
        FUNCT_W'(6'h06): dec_sel = SEL_W'(5'h01);
        FUNCT_W'(6'h18): dec_sel = SEL_W'(5'h02);
        FUNCT_W'(6'h19): dec_sel = SEL_W'(5'h03);
        FUNCT_W'(6'h1A): dec_sel = SEL_W'(5'h04);
        FUNCT_W'(6'h1B): dec_sel = SEL_W'(5'h05);
        FUNCT_W'(6'h2A): dec_sel = SEL_W'(5'h0E);
        FUNCT_W'(6'h2B): dec_sel = SEL_W'(5'h0F);
        default: begin
          // add..nor occupy a contiguous funct range mapping onto a contiguous select range
          if (funct >= FUNCT_W'(6'h20) && funct <= FUNCT_W'(6'h27)) begin
            dec_sel = SEL_W'(funct - FUNCT_W'(6'h1A));
          end else begin
            dec_illegal = 1'b1;
          end
        end
      endcase
    end else begin
      case (alu_op)
        OP_W'(8):  dec_sel = SEL_W'(5'h06);
        OP_W'(9):  dec_sel = SEL_W'(5'h07);
        OP_W'(10): dec_sel = SEL_W'(5'h0E);
        OP_W'(11): dec_sel = SEL_W'(5'h0F);
        OP_W'(12): dec_sel = SEL_W'(5'h0A);
        OP_W'(13): dec_sel = SEL_W'(5'h0B);
        OP_W'(14): dec_sel = SEL_W'(5'h0C);
        OP_W'(15): dec_sel = SEL_W'(5'h10);
        default:   dec_illegal = 1'b1;
      endcase
    end
    dec_mul = !dec_illegal && (dec_sel == SEL_W'(5'h02) || dec_sel == SEL_W'(5'h03));
    dec_div = !dec_illegal && (dec_sel == SEL_W'(5'h04) || dec_sel == SEL_W'(5'h05));
  end

  always_comb begin
    in_ready = !flush && ((state_q == StIdle) || (state_q == StOut && out_ready));
    accept   = in_valid && in_ready;

    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    shamt_d   = shamt_q;
    illegal_d = illegal_q;

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StOut: begin
          if (accept) begin
            sel_d     = dec_sel;
            shamt_d   = dec_shamt;
            illegal_d = dec_illegal;
            if (dec_mul && MulMc) begin
              state_d = StBusy;
              cnt_d   = MulCnt;
            end else if (dec_div && DivMc) begin
              state_d = StBusy;
              cnt_d   = DivCnt;
            end else begin
              state_d = StOut;
              cnt_d   = '0;
            end
          end else if (state_q == StOut && out_ready) begin
            state_d = StIdle;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_d = StOut;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      shamt_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      shamt_q   <= shamt_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == StOut);
  assign busy      = (state_q == StBusy);
  assign alu_sel   = sel_q;
  assign shamt_imm = shamt_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctl_mc.sv
// Self-checking bench for alu_ctl_mc: directed scenarios plus randomized transactions
// compared against a table-driven decode and latency model.
module tb_alu_ctl_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [15:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_sel;
  logic        shamt_imm;
  logic        illegal;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference tables: -1 marks an illegal encoding.
  int r_sel[64];
  bit r_sh[64];
  int i_sel[16];
  int legal_f[$];

  alu_ctl_mc dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .immediate (immediate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_sel   (alu_sel),
    .shamt_imm (shamt_imm),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  task automatic build_tables();
    for (int i = 0; i < 64; i++) begin r_sel[i] = -1; r_sh[i] = 1'b0; end
    r_sel[6'h00] = 0; r_sh[6'h00] = 1'b1;
    r_sel[6'h02] = 1; r_sh[6'h02] = 1'b1;
    r_sel[6'h04] = 0; r_sel[6'h06] = 1;
    for (int i = 0; i < 4; i++) r_sel[6'h18 + i] = 2 + i;
    for (int i = 0; i < 8; i++) r_sel[6'h20 + i] = 6 + i;
    r_sel[6'h2A] = 14; r_sel[6'h2B] = 15;
    i_sel = '{-1, -1, -1, -1, -1, -1, -1, -1, 6, 7, 14, 15, 10, 11, 12, 16};
    for (int i = 0; i < 64; i++) if (r_sel[i] >= 0) legal_f.push_back(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'h0; immediate = 16'h0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (alu_sel !== 5'h00) $display("FAIL reset_sel got %0h exp 0", alu_sel); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_ov got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if ({shamt_imm, illegal} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {shamt_imm, illegal}); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    alu_op = 4'h0; immediate = 16'h0020; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %b exp 1", in_ready); else n_pass++;
    tick();
    n_checks++; if ({out_valid, alu_sel} !== {1'b1, 5'h06}) $display("FAIL b2b_add got ov=%b sel=%0h exp ov=1 sel=6", out_valid, alu_sel); else n_pass++;
    immediate = 16'h002B;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b exp 1", in_ready); else n_pass++;
    tick();
    n_checks++; if ({out_valid, alu_sel} !== {1'b1, 5'h0F}) $display("FAIL b2b_sltu got ov=%b sel=%0h exp ov=1 sel=f", out_valid, alu_sel); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++; if ({out_valid, alu_sel} !== {1'b0, 5'h0F}) $display("FAIL b2b_idle got ov=%b sel=%0h exp ov=0 sel=f", out_valid, alu_sel); else n_pass++;
  endtask

  task automatic test_div();
    int bad;
    alu_op = 4'h0; immediate = 16'h001A; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      n_checks++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        $display("FAIL div_busy cyc=%0d got busy/rdy/ov=%b exp 100", i, {busy, in_ready, out_valid});
        bad++;
      end else n_pass++;
      tick();
    end
    n_checks++; if ({out_valid, busy, alu_sel} !== {1'b1, 1'b0, 5'h04}) $display("FAIL div_done got ov=%b busy=%b sel=%0h exp 1 0 4", out_valid, busy, alu_sel); else n_pass++;
    tick();
  endtask

  task automatic test_shift();
    alu_op = 4'h0; immediate = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++; if ({out_valid, alu_sel, shamt_imm} !== {1'b1, 5'h01, 1'b1}) $display("FAIL shri got ov=%b sel=%0h sh=%b exp 1 1 1", out_valid, alu_sel, shamt_imm); else n_pass++;
    alu_op = 4'hF;
    tick();
    n_checks++; if ({alu_sel, shamt_imm, illegal} !== {5'h10, 1'b0, 1'b0}) $display("FAIL passb got sel=%0h sh=%b il=%b exp 10 0 0", alu_sel, shamt_imm, illegal); else n_pass++;
  endtask

  task automatic test_illegal();
    alu_op = 4'h3; immediate = 16'h0020; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++; if ({out_valid, illegal, alu_sel} !== {1'b1, 1'b1, 5'h00}) $display("FAIL ill_op got ov=%b il=%b sel=%0h exp 1 1 0", out_valid, illegal, alu_sel); else n_pass++;
    alu_op = 4'h0; immediate = 16'h003F;
    tick();
    n_checks++; if ({out_valid, illegal, alu_sel} !== {1'b1, 1'b1, 5'h00}) $display("FAIL ill_funct got ov=%b il=%b sel=%0h exp 1 1 0", out_valid, illegal, alu_sel); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    alu_op = 4'h0; immediate = 16'h0020; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    immediate = 16'h0022;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, alu_sel} !== {1'b1, 1'b0, 5'h06}) $display("FAIL stall_hold cyc=%0d got ov=%b rdy=%b sel=%0h exp 1 0 6", i, out_valid, in_ready, alu_sel);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_release got rdy=%b exp 1", in_ready); else n_pass++;
    tick();
    n_checks++; if ({out_valid, alu_sel} !== {1'b1, 5'h08}) $display("FAIL stall_next got ov=%b sel=%0h exp 1 8", out_valid, alu_sel); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    alu_op = 4'h0; immediate = 16'h0018; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b exp 1", busy); else n_pass++;
    tick();
    flush = 1'b1; in_valid = 1'b1; immediate = 16'h0020;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", in_ready); else n_pass++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if ({busy, out_valid, in_ready, alu_sel} !== {1'b0, 1'b0, 1'b1, 5'h02}) $display("FAIL flush_after got busy=%b ov=%b rdy=%b sel=%0h exp 0 0 1 2", busy, out_valid, in_ready, alu_sel); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ov cyc=%0d got %b exp 0", i, out_valid); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    alu_op = 4'h0; immediate = 16'h0019; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({busy, out_valid, alu_sel, shamt_imm, illegal} !== 9'b0) $display("FAIL rst_mid got busy=%b ov=%b sel=%0h sh=%b il=%b exp all 0", busy, out_valid, alu_sel, shamt_imm, illegal); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int exp_sel, exp_lat, cnt, k;
    bit exp_sh, exp_il;
    logic [5:0] f;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        alu_op = 4'h0;
        if ($urandom_range(0, 3) != 0) f = 6'(legal_f[$urandom_range(0, legal_f.size() - 1)]);
        else f = 6'($urandom);
      end else begin
        alu_op = 4'($urandom_range(0, 15));
        f = 6'($urandom);
      end
      immediate = {10'($urandom), f};
      if (alu_op == 4'h0) begin exp_sel = r_sel[f]; exp_sh = r_sh[f]; end
      else begin exp_sel = i_sel[alu_op]; exp_sh = 1'b0; end
      exp_il = (exp_sel < 0);
      if (exp_il) exp_sel = 0;
      exp_lat = (exp_sel == 2 || exp_sel == 3) ? 4 : (exp_sel == 4 || exp_sel == 5) ? 16 : 1;

      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      cnt = 1;
      while (out_valid !== 1'b1 && cnt < 40) begin tick(); cnt++; end
      n_checks++; if (cnt != exp_lat) $display("FAIL rnd_lat op=%0h f=%0h got %0d exp %0d", alu_op, f, cnt, exp_lat); else n_pass++;
      n_checks++;
      if ({alu_sel, shamt_imm, illegal} !== {5'(exp_sel), exp_sh, exp_il})
        $display("FAIL rnd_dec op=%0h f=%0h got sel=%0h sh=%b il=%b exp sel=%0h sh=%b il=%b", alu_op, f, alu_sel, shamt_imm, illegal, exp_sel, exp_sh, exp_il);
      else n_pass++;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        tick();
        n_checks++; if ({out_valid, alu_sel} !== {1'b1, 5'(exp_sel)}) $display("FAIL rnd_hold got ov=%b sel=%0h exp 1 %0h", out_valid, alu_sel, exp_sel); else n_pass++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rnd_consume got ov=%b exp 0", out_valid); else n_pass++;
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_back_to_back();
    test_div();
    test_shift();
    test_illegal();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
